dup_adder_error_checker: RTL and testbench
==========================================

// Module: dup_adder_error_checker
// PURPOSE
// - Consumes one result beat of the 64b duplicated carry-select adder (s, s_invert, papb, pab) and checks it.
// - Duplication check: s must equal ~s_invert. Parity check: ^s must equal papb ^ pab.
// - 2-stage pipelined checker with a sticky alarm FSM and a saturating error counter.
// - Sits directly downstream of the adder; its alarm feeds the system fault handler.
// PARAMETERS
// - WIDTH        64  datapath width of s / s_invert
// - CNT_W        8   error counter width
// - LOCK_THRESH  4   error count at which the FSM enters LOCK (1 <= LOCK_THRESH <= 2**CNT_W-1)
// PORTS
// - clk        in   1         rising-edge clock
// - rst_n      in   1         asynchronous active-low reset
// - in_valid   in   1         beat present on s/s_invert/papb/pab
// - s          in   WIDTH     adder sum
// - s_invert   in   WIDTH     duplicated adder sum, bitwise inverted
// - papb       in   1         pa ^ pb (operand parity)
// - pab        in   1         parity of the adder internal carry-in vector
// - clr_alarm  in   1         one-cycle pulse: clear counter, ALARM -> OK
// - out_valid  out  1         one-cycle pulse, check result valid
// - err_dup    out  1         duplication mismatch on this beat (valid with out_valid)
// - err_par    out  1         parity mismatch on this beat (valid with out_valid)
// - err_cnt    out  CNT_W     erroneous beats counted, saturating
// - alarm      out  1         1 in ALARM or LOCK
// - locked     out  1         1 in LOCK
// BEHAVIOUR
// - Reset (rst_n=0, async): all pipeline regs, out_valid, err_dup, err_par, err_cnt, alarm, locked = 0; FSM = OK.
// - No backpressure: a beat accepted every cycle in_valid=1; back-to-back beats supported.
// - Stage 1 (cycle N+1 after in_valid at N): register dup_diff = s ^ s_invert reduced per byte (AND of each byte),
//   byte parities of s, and pred = papb ^ pab; valid bit follows.
// - Stage 2 (cycle N+2): err_dup = ~&(byte ANDs); err_par = (^byte parities) ^ pred; out_valid=1 for one cycle.
// - err_dup/err_par hold last value when out_valid=0; bench samples only on out_valid.
// - Beat is erroneous if err_dup | err_par; counts once even if both set.
// - err_cnt: +1 per erroneous beat (at the stage-2 edge), saturates at 2**CNT_W-1, no wrap.
// - FSM states: OK, ALARM, LOCK. Updated on the same edge as err_cnt.
//   OK    -> ALARM on erroneous beat.
//   ALARM -> LOCK  when updated err_cnt >= LOCK_THRESH.
//   ALARM -> OK    on clr_alarm with no erroneous beat this cycle.
//   LOCK: exits only on rst_n; clr_alarm ignored (counter not cleared).
// - clr_alarm together with erroneous beat: counter cleared then counted -> err_cnt=1, state ALARM
//   (LOCK if LOCK_THRESH=1).
// - clr_alarm in OK: err_cnt cleared to 0, state stays OK.
// - alarm/locked are registered decodes of FSM state (valid the cycle after the transition edge... i.e. same edge).
// - Reset mid-operation: in-flight beats dropped, no out_valid after rst_n release until new in_valid (latency 2).
// - WIDTH must be a multiple of 8.
// CONFIGURATION
// - Macro DUP_CHECK_FAULT_INJECT_EN.
// - Defined: extra ports inj_en (in,1) and inj_bit (in,$clog2(WIDTH)); when inj_en=1 with in_valid,
//   bit inj_bit of s is flipped before stage 1 (models single-bit upset: sets err_dup and err_par).
// - Undefined: ports absent, s checked unmodified; behaviour otherwise identical.
// TESTING
// - Reset, then s=64'h0123_4567_89AB_CDEF, s_invert=~s, papb^pab=^s, in_valid=1 for 1 cycle
//   -> out_valid at +2 cycles, err_dup=0, err_par=0, err_cnt=0, alarm=0.
// - 1000 back-to-back random a,b through the adder model (as adder TB) -> 1000 out_valid pulses, no errors.
// - s_invert=~s ^ 64'h1 (parity consistent) -> err_dup=1, err_par=0, err_cnt=1, alarm=1, locked=0.
// - s=64'h0, s_invert=~0, papb=1, pab=0 -> err_par=1, err_dup=0; then clr_alarm pulse alone -> err_cnt=0, alarm=0.
// - 4 erroneous beats back-to-back (LOCK_THRESH=4) -> err_cnt 1,2,3,4; locked=1 after 4th;
//   clr_alarm -> still locked, err_cnt=4; rst_n low -> all outputs 0 immediately (async).
// - clr_alarm coincident with erroneous beat in ALARM (err_cnt=2) -> err_cnt=1, alarm=1.
// - CNT_W=2, LOCK_THRESH=3: saturation check -> err_cnt stops at 3; with DUP_CHECK_FAULT_INJECT_EN,
//   inj_en=1, inj_bit=63 on clean beat -> err_dup=1, err_par=1.

Source files
------------

// File: rtl/dup_adder_error_checker.sv
// Two-stage checker for the duplicated carry-select adder: duplication and parity checks,
// saturating error counter and sticky OK/ALARM/LOCK alarm FSM. Optional macro: DUP_CHECK_FAULT_INJECT_EN.
module dup_adder_error_checker #(
  parameter int WIDTH       = 64,
  parameter int CNT_W       = 8,
  parameter int LOCK_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         s,
  input  logic [WIDTH-1:0]         s_invert,
  input  logic                     papb,
  input  logic                     pab,
`ifdef DUP_CHECK_FAULT_INJECT_EN
  input  logic                     inj_en,
  input  logic [$clog2(WIDTH)-1:0] inj_bit,
`endif
  input  logic                     clr_alarm,
  output logic                     out_valid,
  output logic                     err_dup,
  output logic                     err_par,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     alarm,
  output logic                     locked
);

  localparam int NB = WIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(LOCK_THRESH);

  typedef enum logic [1:0] {OK, ALARM, LOCK} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] s_chk;
  logic [NB-1:0]   byte_and_d, byte_par_d;
  logic [NB-1:0]   byte_and, byte_par;
  logic            pred, v1;
  logic            dup_now, par_now, bad;
  logic [CNT_W-1:0] cnt_base, cnt_next;

  // Fault injection flips one sum bit ahead of both checks, so a single upset trips both.
  always_comb begin
    s_chk = s;
`ifdef DUP_CHECK_FAULT_INJECT_EN
    if (inj_en) s_chk[inj_bit] = ~s_chk[inj_bit];
`endif
  end

  always_comb begin
    byte_and_d = '0;
    byte_par_d = '0;
    for (int b = 0; b < NB; b++) begin
      byte_and_d[b] = &(s_chk[8*b +: 8] ^ s_invert[8*b +: 8]);
      byte_par_d[b] = ^s_chk[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      byte_and <= '0;
      byte_par <= '0;
      pred     <= 1'b0;
    end else begin
      v1       <= in_valid;
      byte_and <= byte_and_d;
      byte_par <= byte_par_d;
      pred     <= papb ^ pab;
    end
  end

  // A clear and an erroneous beat on the same edge: clear first, then count.
  always_comb begin
    dup_now  = ~&byte_and;
    par_now  = (^byte_par) ^ pred;
    bad      = v1 & (dup_now | par_now);
    cnt_base = (clr_alarm && state != LOCK) ? '0 : err_cnt;
    cnt_next = (bad && cnt_base != CNT_MAX) ? cnt_base + CNT_W'(1) : cnt_base;
    state_next = state;
    case (state)
      OK:      if (bad) state_next = ALARM;
      ALARM:   if (cnt_next >= THRESH)     state_next = LOCK;
               else if (clr_alarm && !bad) state_next = OK;
      default: state_next = LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OK;
      out_valid <= 1'b0;
      err_dup   <= 1'b0;
      err_par   <= 1'b0;
      err_cnt   <= '0;
      alarm     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= v1;
      if (v1) begin
        err_dup <= dup_now;
        err_par <= par_now;
      end
      err_cnt   <= cnt_next;
      alarm     <= (state_next != OK);
      locked    <= (state_next == LOCK);
    end
  end

endmodule

// File: tb/tb_dup_adder_error_checker.sv
// Scoreboard bench for dup_adder_error_checker (default parameters; covers DUP_CHECK_FAULT_INJECT_EN when defined).
module tb_dup_adder_error_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] s = '0;
  logic [63:0] s_invert = '1;
  logic        papb = 1'b0;
  logic        pab = 1'b0;
  logic        clr_alarm = 1'b0;
  logic        inj_en = 1'b0;
  logic [5:0]  inj_bit = '0;
  logic        out_valid, err_dup, err_par, alarm, locked;
  logic [7:0]  err_cnt;

  typedef struct packed {logic dup; logic par;} exp_t;
  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   ov_count = 0;

  always #5 clk = ~clk;

  dup_adder_error_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .s_invert(s_invert),
    .papb(papb), .pab(pab),
`ifdef DUP_CHECK_FAULT_INJECT_EN
    .inj_en(inj_en), .inj_bit(inj_bit),
`endif
    .clr_alarm(clr_alarm), .out_valid(out_valid), .err_dup(err_dup), .err_par(err_par),
    .err_cnt(err_cnt), .alarm(alarm), .locked(locked)
  );

  // Scoreboard: every out_valid pulse must match the oldest pending beat.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      exp_t e;
      ov_count++;
      checks++;
      if (q.size() == 0) $display("[TB] FAIL unexpected_out_valid got=1 want=0");
      else begin
        e = q.pop_front();
        if (err_dup !== e.dup) $display("[TB] FAIL err_dup got=%b want=%b", err_dup, e.dup);
        else if (err_par !== e.par) $display("[TB] FAIL err_par got=%b want=%b", err_par, e.par);
        else passed++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_beat(input logic [63:0] sv, input logic [63:0] si,
                            input logic pa, input logic pb, input logic inj);
    exp_t e;
    logic [63:0] sc;
    in_valid = 1'b1; s = sv; s_invert = si; papb = pa; pab = pb; inj_en = inj;
    sc = sv;
`ifdef DUP_CHECK_FAULT_INJECT_EN
    if (inj) sc[inj_bit] = ~sc[inj_bit];
`endif
    e.dup = ((sc ^ si) != 64'hFFFF_FFFF_FFFF_FFFF);
    e.par = (^sc) ^ pa ^ pb;
    q.push_back(e);
  endtask

  task automatic idle();
    in_valid = 1'b0; inj_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (q.size() != 0) $display("[TB] FAIL drain pending=%0d want=0", q.size());
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; idle(); clr_alarm = 1'b0; q.delete();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({out_valid, err_dup, err_par, err_cnt, alarm, locked} !== 13'd0)
      $display("[TB] FAIL reset_outputs got=%b want=0", {out_valid, err_dup, err_par, err_cnt, alarm, locked});
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_beat();
    logic [63:0] v = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); drive_beat(v, ~v, ^v, 1'b0, 1'b0);
    @(negedge clk); idle(); #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL latency_early got=%b want=0", out_valid);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) $display("[TB] FAIL latency_two got=%b want=1", out_valid);
    else passed++;
    checks++;
    if (err_cnt !== 8'd0 || alarm !== 1'b0)
      $display("[TB] FAIL clean_state got=cnt%0d/alarm%b want=cnt0/alarm0", err_cnt, alarm);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int start = ov_count;
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] a, b, sum;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sum = a + b;
      @(negedge clk); drive_beat(sum, ~sum, (^a) ^ (^b), ^(sum ^ a ^ b), 1'b0);
    end
    @(negedge clk); idle();
    drain();
    checks++;
    if (ov_count - start != 1000) $display("[TB] FAIL b2b_pulses got=%0d want=1000", ov_count - start);
    else passed++;
    checks++;
    if (err_cnt !== 8'd0 || alarm !== 1'b0) $display("[TB] FAIL b2b_cnt got=%0d want=0", err_cnt);
    else passed++;
  endtask

  task automatic test_dup_error();
    logic [63:0] v = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); drive_beat(v, ~v ^ 64'h1, ^v, 1'b0, 1'b0);
    @(negedge clk); idle();
    drain();
    checks++;
    if (err_cnt !== 8'd1 || alarm !== 1'b1 || locked !== 1'b0)
      $display("[TB] FAIL dup_state got=cnt%0d/a%b/l%b want=cnt1/a1/l0", err_cnt, alarm, locked);
    else passed++;
  endtask

  task automatic test_par_error_and_clear();
    @(negedge clk); drive_beat(64'h0, ~64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); idle();
    drain();
    checks++;
    if (err_cnt !== 8'd2 || alarm !== 1'b1) $display("[TB] FAIL par_state got=cnt%0d/a%b want=cnt2/a1", err_cnt, alarm);
    else passed++;
    @(negedge clk); clr_alarm = 1'b1;
    @(negedge clk); clr_alarm = 1'b0; #1;
    checks++;
    if (err_cnt !== 8'd0 || alarm !== 1'b0) $display("[TB] FAIL clear got=cnt%0d/a%b want=cnt0/a0", err_cnt, alarm);
    else passed++;
  endtask

  task automatic test_lock();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (i >= 2) begin
        checks++;
        if (err_cnt !== 8'(i - 1)) $display("[TB] FAIL lock_count got=%0d want=%0d", err_cnt, i - 1);
        else passed++;
      end
      if (i < 4) drive_beat(64'h0, ~64'h0 ^ 64'h1, 1'b0, 1'b0, 1'b0);
      else idle();
    end
    checks++;
    if (locked !== 1'b1 || alarm !== 1'b1) $display("[TB] FAIL lock_state got=l%b/a%b want=l1/a1", locked, alarm);
    else passed++;
    @(negedge clk); clr_alarm = 1'b1;
    @(negedge clk); clr_alarm = 1'b0; #1;
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd4) $display("[TB] FAIL lock_clr got=l%b/cnt%0d want=l1/cnt4", locked, err_cnt);
    else passed++;
    @(negedge clk); #2 rst_n = 1'b0; q.delete(); #1;
    checks++;
    if ({out_valid, err_dup, err_par, err_cnt, alarm, locked} !== 13'd0)
      $display("[TB] FAIL async_reset got=%b want=0", {out_valid, err_dup, err_par, err_cnt, alarm, locked});
    else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_clr_with_error();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) drive_beat(64'h0, ~64'h0, 1'b1, 1'b0, 1'b0);
      else idle();
    end
    drain();
    checks++;
    if (err_cnt !== 8'd2) $display("[TB] FAIL pre_clr got=%0d want=2", err_cnt);
    else passed++;
    @(negedge clk); drive_beat(64'h0, ~64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); idle(); clr_alarm = 1'b1;
    @(negedge clk); clr_alarm = 1'b0; #1;
    checks++;
    if (err_cnt !== 8'd1 || alarm !== 1'b1 || locked !== 1'b0)
      $display("[TB] FAIL clr_err got=cnt%0d/a%b/l%b want=cnt1/a1/l0", err_cnt, alarm, locked);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    int start;
    @(negedge clk); s = 64'h0; s_invert = 64'h1; in_valid = 1'b1;
    @(negedge clk); idle(); rst_n = 1'b0; q.delete();
    @(negedge clk); rst_n = 1'b1;
    start = ov_count;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (ov_count != start || out_valid !== 1'b0) $display("[TB] FAIL midflight got=%0d want=0", ov_count - start);
    else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      @(negedge clk); drive_beat(64'h0, ~64'h0, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk); idle();
    drain();
    checks++;
    if (err_cnt !== 8'd255 || locked !== 1'b1) $display("[TB] FAIL saturate got=cnt%0d/l%b want=cnt255/l1", err_cnt, locked);
    else passed++;
  endtask

  task automatic test_inject();
`ifdef DUP_CHECK_FAULT_INJECT_EN
    logic [63:0] v = 64'h0123_4567_89AB_CDEF;
    do_reset();
    inj_bit = 6'd63;
    @(negedge clk); drive_beat(v, ~v, ^v, 1'b0, 1'b1);
    @(negedge clk); idle();
    drain();
    checks++;
    if (err_dup !== 1'b1 || err_par !== 1'b1) $display("[TB] FAIL inject got=d%b/p%b want=d1/p1", err_dup, err_par);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_clean_beat();
    test_back_to_back();
    test_dup_error();
    test_par_error_and_clear();
    test_lock();
    test_clr_with_error();
    test_reset_midflight();
    do_reset();
    test_saturation();
    test_inject();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
